// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // One memory word as four bytes; byte 3 is the most significant.
  typedef logic [3:0][7:0] word_t;

  localparam int WORD_OFFSET_W = 2;

  // Clear the byte-within-word bits of a byte address.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & ~((32'd1 << WORD_OFFSET_W) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker for mem_port_arbiter.
// Default: round-robin on ties (the port that was not granted last wins).
// `define ARB_DPORT_PRIORITY_EN: fixed priority, D wins every tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_grant,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

`ifdef ARB_DPORT_PRIORITY_EN
  // Fixed priority ignores the pointer.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  // Choose the winner among the active requests.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    if (i_req && d_req) begin
`ifdef ARB_DPORT_PRIORITY_EN
      grant_owner = OWN_D;
`else
      grant_owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
`endif
    end else if (d_req) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I refill port and the D cache port.
// Each access holds address/data for MEM_LATENCY cycles, then pulses done.
// Optional macro ARB_DPORT_PRIORITY_EN selects fixed D priority instead of
// round-robin (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  MEM_LATENCY = 4,
  localparam int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output word_t       i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  word_t       d_wdata,
  output word_t       d_rdata,
  output logic        d_done,
  output logic [31:0] mem_addr,
  output word_t       mem_data_in,
  input  word_t       mem_data_out,
  output logic        mem_we,
  output logic        busy,
  output arb_owner_t  owner
);

  arb_state_t       state;
  arb_owner_t       last_grant;
  logic [CNT_W-1:0] cnt;
  logic             is_write;
  logic             grant_valid;
  arb_owner_t       grant_owner;

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Access sequencer: grant, hold the memory port for MEM_LATENCY cycles, pulse done.
  // Memory-side outputs are registered; mem_we is raised one edge early so it
  // is high exactly in the final ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= OWN_D;
      owner       <= OWN_I;
      cnt         <= '0;
      is_write    <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      // NOTE: read-data registers are plain flops visible on ports, so they reset too.
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
      i_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= ACCESS;
            owner      <= grant_owner;
            last_grant <= grant_owner;
            cnt        <= CNT_W'(MEM_LATENCY);
            busy       <= 1'b1;
            if (grant_owner == OWN_D) begin
              mem_addr    <= word_addr(d_addr);
              is_write    <= d_we;
              mem_data_in <= d_we ? d_wdata : '0;
              mem_we      <= (MEM_LATENCY == 1) && d_we;
            end else begin
              mem_addr    <= word_addr(i_addr);
              is_write    <= 1'b0;
              mem_data_in <= '0;
              mem_we      <= 1'b0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            if (owner == OWN_D) begin
              d_done <= 1'b1;
              if (!is_write) d_rdata <= mem_data_out;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_data_out;
            end
          end else begin
            mem_we <= is_write && (int'(cnt) == 2);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Instance u_dut4 uses MEM_LATENCY = 4, u_dut1 uses MEM_LATENCY = 1.
// Tie-order expectations follow ARB_DPORT_PRIORITY_EN when it is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 4;

`ifdef ARB_DPORT_PRIORITY_EN
  localparam logic [3:0] TIE_EXP = 4'b1111;
`else
  localparam logic [3:0] TIE_EXP = 4'b1010;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Latency-4 instance
  logic        i_req, d_req, d_we, i_done, d_done, mem_we, busy;
  logic [31:0] i_addr, d_addr, mem_addr;
  word_t       i_rdata, d_rdata, d_wdata, mem_data_in, mem_data_out;
  arb_owner_t  owner;
  logic [31:0] mem0 [0:255];

  // Latency-1 instance
  logic        i_req1, d_req1, i_done1, d_done1, mem_we1, busy1;
  logic [31:0] i_addr1, d_addr1, mem_addr1;
  word_t       i_rdata1, d_rdata1, mem_data_in1, mem_data_out1;
  arb_owner_t  owner1;
  logic [31:0] mem1 [0:255];

  mem_port_arbiter #(.MEM_LATENCY(LAT)) u_dut4 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_we(mem_we), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_done(i_done1),
    .d_req(d_req1), .d_we(1'b0), .d_addr(d_addr1), .d_wdata('0),
    .d_rdata(d_rdata1), .d_done(d_done1),
    .mem_addr(mem_addr1), .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1),
    .mem_we(mem_we1), .busy(busy1), .owner(owner1)
  );

  // Simple memory models: combinational read, write on the rising edge.
  assign mem_data_out  = mem0[mem_addr[9:2]];
  assign mem_data_out1 = mem1[mem_addr1[9:2]];
  always @(posedge clk) begin
    if (mem_we)  mem0[mem_addr[9:2]]  <= mem_data_in;
    if (mem_we1) mem1[mem_addr1[9:2]] <= mem_data_in1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One access on the latency-4 instance; reports when done came, which port
  // pulsed, how often and where mem_we was high, and address errors in ACCESS.
  task automatic access(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int done_k, output logic done_d,
                        output int we_cnt, output int we_k, output int addr_err);
    done_k = 0; done_d = 1'b0; we_cnt = 0; we_k = 0; addr_err = 0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 1; k <= 4 * LAT; k++) begin
      tick();
      if (mem_we) begin we_cnt++; we_k = k; end
      if (k <= LAT && mem_addr != (addr & 32'hFFFF_FFFC)) addr_err++;
      if (i_done || d_done) begin
        done_k = k; done_d = d_done;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic wait_done(output int k, output logic was_d, output arb_owner_t own);
    k = 0; was_d = 1'b0; own = OWN_I;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (i_done || d_done) begin
        k = n; was_d = d_done; own = owner;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         dk, wc, wk, ae, ev;
    logic       dd;
    arb_owner_t own;

    for (int i = 0; i < 256; i++) begin mem0[i] = '0; mem1[i] = '0; end
    mem0[8'h41] = 32'h1122_3344;
    mem1[8'h04] = 32'hA1A2_A3A4;
    mem1[8'h08] = 32'hB1B2_B3B4;

    rst = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = '0;
    i_req1 = 0; d_req1 = 0; i_addr1 = 0; d_addr1 = 0;
    tick(); tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_done", {i_done, d_done}, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    tick();

    // Single I read of unaligned 0x106 -> word 0x104
    access(1'b0, 1'b0, 32'h0000_0106, '0, dk, dd, wc, wk, ae);
    check("iread_latency", dk, LAT + 1);
    check("iread_port", dd, 0);
    check("iread_we_cnt", wc, 0);
    check("iread_addr_err", ae, 0);
    check("iread_rdata", i_rdata, 32'h1122_3344);
    check("iread_busy_after", busy, 0);

    // D write 0xDEADBEEF to 0x200
    access(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, dk, dd, wc, wk, ae);
    check("dwr_latency", dk, LAT + 1);
    check("dwr_port", dd, 1);
    check("dwr_we_cnt", wc, 1);
    check("dwr_we_pos", wk, LAT);
    check("dwr_addr_err", ae, 0);
    check("dwr_mem", mem0[8'h80], 32'hDEAD_BEEF);
    check("dwr_owner", owner, 1);

    // D read back 0x200; I side untouched
    access(1'b1, 1'b0, 32'h0000_0200, '0, dk, dd, wc, wk, ae);
    check("drd_latency", dk, LAT + 1);
    check("drd_we_cnt", wc, 0);
    check("drd_rdata", d_rdata, 32'hDEAD_BEEF);
    check("drd_i_rdata", i_rdata, 32'h1122_3344);

    // A write must leave d_rdata alone
    access(1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, dk, dd, wc, wk, ae);
    check("dwr2_mem", mem0[8'h81], 32'hCAFE_F00D);
    check("dwr2_d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Withdrawal two cycles into a write; later input changes ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h0BAD_F00D;
    tick(); tick();
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0000_03F0; d_wdata = 32'hFFFF_FFFF;
    dk = 0;
    for (int n = 3; n <= 12; n++) begin
      tick();
      if (d_done) begin dk = n; break; end
    end
    check("wdraw_done", dk, LAT + 1);
    check("wdraw_mem", mem0[8'hC0], 32'h0BAD_F00D);
    check("wdraw_other_mem", mem0[8'hFC], 0);
    tick();
    check("wdraw_idle", busy, 0);

    // Asynchronous reset in the 2nd ACCESS cycle of an I read
    i_req = 1'b1; i_addr = 32'h0000_0104;
    tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_we", mem_we, 0);
    check("arst_i_rdata", i_rdata, 0);
    @(negedge clk);
    ev = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (i_done || d_done) ev++;
    end
    check("arst_no_done", ev, 0);
    rst = 1'b0;
    dk = 0;
    for (int n = 1; n <= 2 * LAT; n++) begin
      tick();
      if (i_done) begin dk = n; break; end
    end
    check("arst_recover_latency", dk, LAT + 1);
    check("arst_recover_rdata", i_rdata, 32'h1122_3344);
    i_req = 1'b0;
    tick();

    // Both requests held from reset: tie order
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h0000_0104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wait_done(dk, dd, own);
      check("tie_spacing", dk, (j == 0) ? LAT + 1 : LAT + 2);
      check("tie_port", dd, TIE_EXP[j]);
      check("tie_owner", own, TIE_EXP[j]);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // MEM_LATENCY = 1: both held, one completion every 3 cycles
    rst = 1'b1;
    i_req1 = 1'b1; i_addr1 = 32'h0000_0010;
    d_req1 = 1'b1; d_addr1 = 32'h0000_0020;
    tick();
    rst = 1'b0;
    ev = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (i_done1 || d_done1) begin
        if (ev < 4) begin
          check("l1_time", n, 3 * ev + 2);
          check("l1_port", d_done1, TIE_EXP[ev]);
          if (d_done1) check("l1_d_rdata", d_rdata1, 32'hB1B2_B3B4);
          else         check("l1_i_rdata", i_rdata1, 32'hA1A2_A3A4);
        end
        ev++;
      end
    end
    check("l1_count", ev, 4);
    check("l1_we", mem_we1, 0);
    i_req1 = 1'b0; d_req1 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
